act_feeder: RTL and testbench

Activation feeder for the CNN inference datapath: holds one MAP_SIZE×MAP_SIZE input map and one k×k kernel. On `start` it streams the map into the accelerator's `activation`/`ce` input in raster order, then flushes the pipeline with zero activations until the accelerator raises `end_op`. It is the transmit end of the accelerator's input interface and sits between the host load port and the accelerator.

---
 rtl/act_feeder_if.sv | 35 +++
 rtl/act_feeder.sv | 131 +++++++++++++
 tb/tb_act_feeder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/act_feeder_if.sv
// Host-load and accelerator-side bus of the activation feeder.
// master = feeder (drives activation/ce/weight1/status), slave = host + accelerator side.
interface act_feeder_if #(
  parameter int MAP_SIZE = 10,
  parameter int k        = 3,
  parameter int N        = 8,
  parameter int AW       = 7
);
  localparam int WI = (k * k > 1) ? $clog2(k * k) : 1;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [N-1:0]      wr_data;
  logic              w_wr_en;
  logic [WI-1:0]     w_idx;
  logic [N-1:0]      w_data;
  logic              start;
  logic              hold;
  logic              end_op;
  logic [N-1:0]      activation;
  logic              ce;
  logic [k*k*N-1:0]  weight1;
  logic              busy;
  logic              done;
  logic              timeout;

  modport master (
    input  wr_en, wr_addr, wr_data, w_wr_en, w_idx, w_data, start, hold, end_op,
    output activation, ce, weight1, busy, done, timeout
  );
  modport slave (
    output wr_en, wr_addr, wr_data, w_wr_en, w_idx, w_data, start, hold, end_op,
    input  activation, ce, weight1, busy, done, timeout
  );
endinterface

// File: rtl/act_feeder.sv
// Activation feeder: streams a MAP_SIZE x MAP_SIZE frame in raster order, then flushes with zeros.
// Optional drain timeout enabled by defining FEEDER_TIMEOUT_EN.
module act_feeder #(
  parameter int MAP_SIZE  = 10,
  parameter int k         = 3,
  parameter int N         = 8,
  parameter int DRAIN_MAX = 64,
  parameter int AW        = 7
) (
  input  logic         clk,
  input  logic         global_rst_n,
  act_feeder_if.master bus
);
  localparam int M2I = MAP_SIZE * MAP_SIZE;
  localparam int KK  = k * k;
  localparam int WI  = (KK > 1) ? $clog2(KK) : 1;
  localparam logic [AW:0] M2  = (AW+1)'(M2I);
  localparam logic [WI:0] KKV = (WI+1)'(KK);

  if ((1 << AW) < M2I || DRAIN_MAX < 1) begin : g_bad_cfg
    $error("act_feeder: AW too small for MAP_SIZE, or DRAIN_MAX < 1");
  end

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_nxt;

  logic [N-1:0]    mem [M2I];
  logic [AW:0]     pix_cnt;
  logic            rd_vld;
  logic [N-1:0]    rd_data, act_q;
  logic            ce_q, done_q, drain_hit;
  logic [KK*N-1:0] w_q;
  logic            idle, issue, last_out, load_ok, wload_ok;

  assign idle     = (state == IDLE);
  // hold freezes the whole read pipeline, so a stalled pixel is re-presented, never lost
  assign issue    = (state == STREAM) && !bus.hold && (pix_cnt != M2);
  assign last_out = (state == STREAM) && !bus.hold && rd_vld && (pix_cnt == M2);
  assign load_ok  = idle && bus.wr_en   && ({1'b0, bus.wr_addr} < M2);
  assign wload_ok = idle && bus.w_wr_en && ({1'b0, bus.w_idx} < KKV);

  always_ff @(posedge clk or negedge global_rst_n)
    if (!global_rst_n) state <= IDLE;
    else               state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = STREAM;
      STREAM:  if (last_out) state_nxt = DRAIN;
      DRAIN:   if (bus.end_op || drain_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_ok) mem[bus.wr_addr] <= bus.wr_data;
    if (issue)   rd_data <= mem[pix_cnt[AW-1:0]];
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      pix_cnt <= '0;
      rd_vld  <= 1'b0;
      act_q   <= '0;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
      w_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (wload_ok) w_q[int'(bus.w_idx)*N +: N] <= bus.w_data;
      case (state)
        IDLE: begin
          ce_q   <= 1'b0;
          rd_vld <= 1'b0;
          if (bus.start) pix_cnt <= '0;
        end
        STREAM: begin
          if (bus.hold) ce_q <= 1'b0;
          else begin
            rd_vld <= issue;
            if (issue)  pix_cnt <= pix_cnt + 1'b1;
            if (rd_vld) act_q   <= rd_data;
            ce_q <= rd_vld;
          end
        end
        DRAIN: begin
          if (bus.end_op || drain_hit) begin
            ce_q   <= 1'b0;
            act_q  <= '0;
            done_q <= 1'b1;
          end else begin
            ce_q <= !bus.hold;
            if (!bus.hold) act_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_MAX + 1);
  logic [DW-1:0] drain_cnt;
  logic          timeout_q;

  assign drain_hit = (drain_cnt == DW'(DRAIN_MAX));

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      drain_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != DRAIN) drain_cnt <= '0;
      else if (!bus.end_op && !drain_hit && !bus.hold) drain_cnt <= drain_cnt + 1'b1;
      if (idle && bus.start) timeout_q <= 1'b0;
      else if (state == DRAIN && drain_hit && !bus.end_op) timeout_q <= 1'b1;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign drain_hit   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.activation = act_q;
  assign bus.ce         = ce_q;
  assign bus.weight1    = w_q;
  assign bus.busy       = !idle;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_act_feeder.sv
// Bench for act_feeder: queue-based frame model checked every cycle, plus directed literal checks.
module tb_act_feeder;
  localparam int MS = 10, K = 3, N = 8, DM = 64, AW = 7, M2 = MS * MS;

  logic clk = 1'b0;
  logic global_rst_n = 1'b0;
  always #5 clk = ~clk;

  act_feeder_if #(.MAP_SIZE(MS), .k(K), .N(N), .AW(AW)) bus();
  act_feeder #(.MAP_SIZE(MS), .k(K), .N(N), .DRAIN_MAX(DM), .AW(AW)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .bus(bus)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [N-1:0] tb_mem [M2];
  logic [N-1:0] exp_q [$];
  int n_seen, drain_seen, gap, first_pix_cyc, first_drain_cyc, t0;
  logic [N-1:0] pix40, first_val, prev_act;
  logic hold_q = 1'b0;
  logic [K*K*N-1:0] w_exp;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic load_mem(input int pat);
    for (int i = 0; i < M2; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(i);
      bus.wr_data = (pat == 0) ? N'(i) : N'((i * 37 + 11) & 255);
      tb_mem[i]   = bus.wr_data;
      nxt();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic start_frame();
    exp_q.delete();
    for (int i = 0; i < M2; i++) exp_q.push_back(tb_mem[i]);
    n_seen = 0; drain_seen = 0; gap = 0; first_pix_cyc = -1; first_drain_cyc = -1;
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic pulse_end();
    bus.end_op = 1'b1;
    nxt();
    bus.end_op = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    hold_q <= bus.hold;
  end

  // Model: a frame is the queue of its pixels in raster order followed by zeros until done
  always @(negedge clk) begin
    logic [N-1:0] e;
    if (global_rst_n) begin
      if (bus.busy && hold_q) begin
        chk("hold_ce", bus.ce, 1'b0);
        chk("hold_act", bus.activation, prev_act);
      end
      if (bus.ce) begin
        chk("ce_busy", bus.busy, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pixel", bus.activation, e);
          if (n_seen == 0) begin first_pix_cyc = cyc; first_val = bus.activation; end
          if (n_seen == 40) pix40 = bus.activation;
          n_seen++;
        end else begin
          chk("drain_act", bus.activation, 0);
          if (drain_seen == 0) first_drain_cyc = cyc;
          drain_seen++;
        end
      end else if (bus.busy && n_seen > 0 && exp_q.size() > 0) gap++;
      if (bus.done) begin
        chk("done_busy", bus.busy, 1'b0);
        chk("done_all_px", exp_q.size(), 0);
      end
    end
    prev_act = bus.activation;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.w_wr_en = 0; bus.w_idx = '0; bus.w_data = '0;
    bus.start = 0; bus.hold = 0; bus.end_op = 0;
    repeat (3) nxt();
    chk("rst_ce", bus.ce, 0);
    chk("rst_act", bus.activation, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_weight", bus.weight1, 0);
    global_rst_n = 1'b1;
    nxt();

    // weights 1..9 into slots 0..8
    for (int i = 0; i < K * K; i++) begin
      bus.w_wr_en = 1'b1; bus.w_idx = 4'(i); bus.w_data = 8'(i + 1);
      nxt();
    end
    bus.w_wr_en = 1'b0;
    w_exp = 72'h090807060504030201;
    chk("weight_load", bus.weight1, w_exp);
    bus.w_wr_en = 1'b1; bus.w_idx = 4'd9; bus.w_data = 8'hFF;
    nxt();
    bus.w_wr_en = 1'b0;
    chk("weight_oob_drop", bus.weight1, w_exp);

    // frame 1: pixels 0..99, no hold, end_op after 5 drain cycles
    load_mem(0);
    start_frame();
    chk("busy_rise", bus.busy, 1'b1);
    chk("lat_ce_t0", bus.ce, 1'b0);
    nxt();
    chk("lat_ce_t1", bus.ce, 1'b0);
    for (int i = 0; i < 300 && drain_seen < 5; i++) nxt();
    chk("wait_drain5", drain_seen >= 5, 1'b1);
    chk("first_pix_lat", first_pix_cyc - t0, 2);
    chk("first_pix_val", first_val, 0);
    chk("first_drain_lat", first_drain_cyc - t0, 2 + M2);
    chk("f1_count", n_seen, M2);
    chk("f1_gap", gap, 0);
    pulse_end();
    chk("end_ce", bus.ce, 1'b0);
    chk("end_done", bus.done, 1'b1);
    chk("end_busy", bus.busy, 1'b0);
    chk("end_drain5", drain_seen, 5);
    nxt();
    chk("done_one_cycle", bus.done, 1'b0);

    // frame 2: ignored loads/start while busy, 3-cycle hold at pixel 40, start+end_op together
    load_mem(1);
    start_frame();
    bus.wr_en = 1'b1; bus.wr_addr = 7'd5; bus.wr_data = 8'hEE;
    bus.w_wr_en = 1'b1; bus.w_idx = 4'd0; bus.w_data = 8'hAA;
    nxt();
    bus.wr_en = 1'b0; bus.w_wr_en = 1'b0;
    for (int i = 0; i < 300 && n_seen < 20; i++) nxt();
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    for (int i = 0; i < 300 && n_seen < 40; i++) nxt();
    chk("wait_px40", n_seen, 40);
    bus.hold = 1'b1;
    repeat (3) nxt();
    bus.hold = 1'b0;
    for (int i = 0; i < 300 && drain_seen < 2; i++) nxt();
    chk("wait_drain2", drain_seen >= 2, 1'b1);
    chk("hold_gap", gap, 3);
    chk("pix40_val", pix40, 211);
    chk("f2_count", n_seen, M2);
    chk("weight_busy_drop", bus.weight1, w_exp);
    bus.start = 1'b1; bus.end_op = 1'b1;
    nxt();
    bus.start = 1'b0; bus.end_op = 1'b0;
    chk("endwin_done", bus.done, 1'b1);
    chk("endwin_busy", bus.busy, 1'b0);
    nxt();
    chk("endwin_no_restart", bus.busy, 1'b0);

`ifdef FEEDER_TIMEOUT_EN
    start_frame();
    for (int i = 0; i < 400; i++) begin
      nxt();
      if (bus.done) break;
    end
    chk("to_done", bus.done, 1'b1);
    chk("to_flag", bus.timeout, 1'b1);
    chk("to_drain_cnt", drain_seen, DM);
    chk("to_busy", bus.busy, 1'b0);
    start_frame();
    chk("to_clear", bus.timeout, 1'b0);
`else
    start_frame();
    for (int i = 0; i < 400 && drain_seen < 70; i++) nxt();
    chk("no_to_flag", bus.timeout, 1'b0);
    chk("no_to_busy", bus.busy, 1'b1);
    pulse_end();
    chk("no_to_done", bus.done, 1'b1);
    start_frame();
`endif

    // reset mid-frame at pixel 50
    for (int i = 0; i < 300 && n_seen < 50; i++) nxt();
    global_rst_n = 1'b0;
    #1;
    chk("mid_rst_ce", bus.ce, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_act", bus.activation, 0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_weight", bus.weight1, 0);
    exp_q.delete();
    repeat (2) begin
      nxt();
      chk("rst_hold_done", bus.done, 1'b0);
    end
    global_rst_n = 1'b1;
    nxt();
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_done", bus.done, 1'b0);

    // frame after reset: buffer retained, streams from pixel 0
    start_frame();
    for (int i = 0; i < 20 && first_pix_cyc < 0; i++) nxt();
    chk("rst_first_lat", first_pix_cyc - t0, 2);
    chk("rst_first_val", first_val, 11);
    for (int i = 0; i < 300 && drain_seen < 1; i++) nxt();
    chk("wait_drain1", drain_seen >= 1, 1'b1);
    pulse_end();
    chk("f5_done", bus.done, 1'b1);
    chk("f5_count", n_seen, M2);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
